// File: rtl/wide_add_pkg.sv
// Shared constants and FSM state type for the word-serial wide adder.
package wide_add_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq.
// WIDE_ADD_SEQ_SUB_EN adds the in_sub request bit.
interface wide_add_seq_if #(parameter int unsigned NWORDS = 4);
   import wide_add_pkg::*;

   localparam int unsigned W = WORD_W * NWORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
   logic         in_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;

   modport master (
`ifdef WIDE_ADD_SEQ_SUB_EN
      output in_sub,
`endif
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
`ifdef WIDE_ADD_SEQ_SUB_EN
      input  in_sub,
`endif
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );

endinterface

// File: rtl/adder.sv
// 32-bit Kogge-Stone prefix adder with carry-in and carry-out.
module adder (
   output logic        cout,
   output logic [31:0] sum,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin
);

   logic [31:0] half;
   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;

   assign half = a ^ b;

   // After the loop g[i]/p[i] are group generate/propagate over bits [i:0].
   always_comb begin
      g = a & b;
      p = a ^ b;
      for (int unsigned k = 0; k < 5; k++) begin
         g = g | (p & (g << (1 << k)));
         p = p & ((p << (1 << k)) | ((32'd1 << (1 << k)) - 32'd1));
      end
      c = g | (p & {32{cin}});
   end

   assign sum  = half ^ {c[30:0], cin};
   assign cout = c[31];

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial NWORDS x 32-bit adder: one 32-bit word per cycle through a shared adder.
// WIDE_ADD_SEQ_SUB_EN enables A-B via in_sub (B inverted, carry-in forced to 1).
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int unsigned NWORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   wide_add_seq_if.slave bus
);

   localparam int unsigned IW = $clog2(NWORDS);

   state_t state, state_nx;

   logic [NWORDS-1:0][WORD_W-1:0] a_w;
   logic [NWORDS-1:0][WORD_W-1:0] b_w;
   logic [NWORDS-1:0][WORD_W-1:0] s_w;
   logic [IW-1:0]                 idx;
   logic                          carry;
   logic                          cout_r;
   logic                          accept;
   logic                          step;
   logic                          last;
   logic                          rdy;
   logic                          vld;
   logic [WORD_W-1:0]             wa;
   logic [WORD_W-1:0]             wb;
   logic [WORD_W-1:0]             ws;
   logic                          wc;
`ifdef WIDE_ADD_SEQ_SUB_EN
   logic                          sub_r;
`endif

   assign last = (idx == IW'(NWORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rdy      = 1'b0;
      vld      = 1'b0;
      accept   = 1'b0;
      step     = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (bus.in_valid) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            vld = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Handshakes are masked while reset is held, whatever the current state.
      if (rst) begin
         rdy    = 1'b0;
         vld    = 1'b0;
         accept = 1'b0;
         step   = 1'b0;
      end
   end

   assign wa = a_w[idx];
`ifdef WIDE_ADD_SEQ_SUB_EN
   assign wb = b_w[idx] ^ {WORD_W{sub_r}};
`else
   assign wb = b_w[idx];
`endif

   adder u_add (
      .cout (wc),
      .sum  (ws),
      .a    (wa),
      .b    (wb),
      .cin  (carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         s_w    <= '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
         sub_r  <= 1'b0;
`endif
      end else if (accept) begin
         a_w   <= bus.in_a;
         b_w   <= bus.in_b;
         idx   <= '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
         sub_r <= bus.in_sub;
         carry <= bus.in_sub | bus.in_cin;
`else
         carry <= bus.in_cin;
`endif
      end else if (step) begin
         s_w[idx] <= ws;
         carry    <= wc;
         if (last) cout_r <= wc;
         else      idx    <= idx + 1'b1;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.out_sum   = s_w;
   assign bus.out_cout  = cout_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed cases, abort-by-reset, random stalls.
// Define WIDE_ADD_SEQ_SUB_EN to also exercise subtraction.
module tb_wide_add_seq;
   import wide_add_pkg::*;

   localparam int unsigned NWORDS = 4;
   localparam int unsigned W      = WORD_W * NWORDS;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wide_add_seq_if #(.NWORDS(NWORDS)) bus ();

   wide_add_seq #(.NWORDS(NWORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   int unsigned ncmp  = 0;
   int unsigned nfail = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_wide();
      logic [W-1:0] r;
      for (int unsigned i = 0; i < NWORDS; i++) r[i*WORD_W +: WORD_W] = $urandom;
      return r;
   endfunction

   // Drive one operand set until accepted, then scramble the inputs and log the expected result.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      exp_t         e;
      logic         acc;
      logic [W-1:0] bb;
      logic         cc;
      int unsigned  n;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
      bus.in_sub   = sub;
`endif
      bus.in_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         acc = bus.in_ready;
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      bus.in_a     = rnd_wide();
      bus.in_b     = rnd_wide();
      bus.in_cin   = 1'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
      bus.in_sub   = 1'($urandom);
`endif
      if (!acc) check("accept_timeout", W'(acc), W'(1));
      bb = sub ? ~b : b;
      cc = sub ? 1'b1 : cin;
      {e.cout, e.sum} = {1'b0, a} + {1'b0, bb} + (W + 1)'(cc);
      sb.push_back(e);
   endtask

   // Must be called right after send(): measures latency from the accepting edge.
   task automatic receive(input int unsigned stall);
      exp_t         e;
      logic [W-1:0] s0;
      logic         c0;
      int unsigned  n;
      n = 0;
      while (!bus.out_valid && n < 4 * NWORDS + 8) begin
         tick();
         n++;
      end
      check("out_valid", W'(bus.out_valid), W'(1));
      check("latency", W'(n), W'(NWORDS));
      e.sum  = '0;
      e.cout = 1'b0;
      if (sb.size() != 0) e = sb.pop_front();
      check("sum", bus.out_sum, e.sum);
      check("cout", W'(bus.out_cout), W'(e.cout));
      s0 = bus.out_sum;
      c0 = bus.out_cout;
      for (int unsigned i = 0; i < stall; i++) begin
         tick();
         check("hold_sum", bus.out_sum, s0);
         check("hold_cout", W'(bus.out_cout), W'(c0));
         check("hold_valid", W'(bus.out_valid), W'(1));
         check("stall_in_ready", W'(bus.in_ready), W'(0));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("post_hs_in_ready", W'(bus.in_ready), W'(1));
      check("post_hs_out_valid", W'(bus.out_valid), W'(0));
   endtask

   initial begin
      logic [W-1:0] ones;
      logic         sub;
      ones          = '1;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
      bus.in_sub    = 1'b0;
`endif
      bus.out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", W'(bus.in_ready), W'(0));
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_sum", bus.out_sum, '0);
      check("rst_cout", W'(bus.out_cout), W'(0));
      rst = 1'b0;
      #1;
      check("idle_in_ready", W'(bus.in_ready), W'(1));

      // Carry out of word 0 into word 1
      send(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0);
      receive(0);

      // All-ones plus carry-in wraps to zero
      send(ones, '0, 1'b1, 1'b0);
      receive(0);

      // Result held through a five-cycle consumer stall
      send(rnd_wide(), rnd_wide(), 1'b1, 1'b0);
      receive(5);

      // Reset mid-operation (idx==2) aborts it
      send(rnd_wide(), rnd_wide(), 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort_rst_in_ready", W'(bus.in_ready), W'(0));
      check("abort_rst_out_valid", W'(bus.out_valid), W'(0));
      check("abort_rst_sum", bus.out_sum, '0);
      rst = 1'b0;
      void'(sb.pop_back());
      #1;
      check("abort_in_ready", W'(bus.in_ready), W'(1));
      for (int unsigned i = 0; i < NWORDS + 2; i++) begin
         tick();
         check("abort_no_valid", W'(bus.out_valid), W'(0));
      end
      send(W'(5), W'(7), 1'b0, 1'b0);
      receive(0);

`ifdef WIDE_ADD_SEQ_SUB_EN
      send(W'(3), W'(5), 1'b0, 1'b1);
      receive(0);
      send(W'(5), W'(3), 1'b0, 1'b1);
      receive(1);
`endif

      // Random back-to-back traffic with random stalls
      for (int unsigned t = 0; t < 500; t++) begin
`ifdef WIDE_ADD_SEQ_SUB_EN
         sub = 1'($urandom);
`else
         sub = 1'b0;
`endif
         case ($urandom_range(0, 7))
            0:       send(ones, rnd_wide(), 1'($urandom), sub);
            1:       send(rnd_wide(), ones, 1'b1, sub);
            default: send(rnd_wide(), rnd_wide(), 1'($urandom), sub);
         endcase
         receive($urandom_range(0, 3));
      end

      check("sb_drained", W'(sb.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
      $finish;
   end

endmodule
